rr_stage: RTL
=============

RR_STAGE -- requirements
Module: rr_stage

Interface
REQ-001 SHALL have ports `clk in 1` (single clock, rising edge) and `rst in 1` (synchronous, active-high reset).
REQ-002 SHALL have `id_valid in 1`, `id_pc in 16`, `id_instr in 16`, `id_src1 in 3`, `id_src2 in 3`, `id_dst in 3`, `id_wb_en in 1`, `id_is_load in 1`: the decoded instruction offered by ID.
REQ-003 SHALL have `rf_a1 out 3` and `rf_a2 out 3`, plus `rf_d1 in 16` and `rf_d2 in 16`: combinational read ports of the register file.
REQ-004 SHALL have `ex_result in 16` (ALU result of the instruction held in the rr_* register) and `ex_stall in 1` (EX cannot accept).
REQ-005 SHALL have `mem_valid in 1`, `mem_dst in 3`, `mem_wb_en in 1`, `mem_result in 16`: the MEM stage result, load data included.
REQ-006 SHALL have `wb_en in 1`, `wb_dst in 3`, `wb_data in 16`: the same signals that drive the register-file write port.
REQ-007 SHALL have `flush in 1`: branch/jump redirect that kills the instruction entering this stage.
REQ-008 SHALL have `stall_out out 1`: holds IF/ID this cycle.
REQ-009 SHALL have registered outputs `rr_valid 1`, `rr_pc 16`, `rr_instr 16`, `rr_op1 16`, `rr_op2 16`, `rr_dst 3`, `rr_wb_en 1`, `rr_is_load 1`.
REQ-010 SHALL have `stall_count out 16`: saturating count of load-use bubbles.

Function
REQ-011 SHALL drive rf_a1 = id_src1 and rf_a2 = id_src2 combinationally.
REQ-012 SHALL resolve each operand with this priority:
- src==0 gives id_pc (R0 is the PC).
- EX hit: rr_valid & rr_wb_en & !rr_is_load & rr_dst==src gives ex_result.
- MEM hit: mem_valid & mem_wb_en & mem_dst==src gives mem_result.
- WB hit: wb_en & wb_dst==src gives wb_data.
- Otherwise rf_d1 or rf_d2.
REQ-013 SHALL forward only for destinations 1..7; a write to R0 never forwards.
REQ-014 SHALL flag a load-use hazard when id_valid & rr_valid & rr_is_load & rr_wb_en & rr_dst!=0 & (rr_dst==id_src1 | rr_dst==id_src2).
REQ-015 SHALL drive stall_out = (hazard | ex_stall) & !flush, combinationally.
REQ-016 SHALL update the rr_* register each clock according to the first matching case:
- rst: clear the register.
- flush: clear rr_valid.
- ex_stall: hold every rr_* field.
- hazard: set rr_valid to 0 (bubble); other fields don't-care.
- else: load the ID fields and the resolved operands, with rr_valid = id_valid.
REQ-017 SHALL resolve the operand again each cycle while ID is held, so a value from MEM or WB that arrives during the stall is captured.
REQ-018 SHALL increment stall_count by 1 on each cycle in which a hazard bubble is inserted, and hold it at 16'hFFFF once reached.
REQ-019 SHALL give latency 1: an accepted ID instruction appears on rr_* on the next rising edge.
REQ-020 SHALL give flush precedence over a simultaneous hazard or ex_stall; the hazard bubble does not increment stall_count in that cycle.

Reset
REQ-021 SHALL, on a clock edge with rst high, set rr_valid=0, rr_pc=0, rr_instr=0, rr_op1=0, rr_op2=0, rr_dst=0, rr_wb_en=0, rr_is_load=0 and stall_count=0, overriding any other input.
REQ-022 SHALL drive stall_out=0 while rst is high, and resolve no hazard from the cleared register in the first cycle after reset.

Structure
REQ-023 SHALL take REG_PC (3'd0), DATA_W (16) and REG_AW (3) from the shared package proc_pkg.
REQ-024 SHALL implement operand resolution as sub-module fwd_mux, instantiated twice (operand 1 and operand 2).

Verification
REQ-025 SHALL cover: R3=0x0011 in file, no hits, src1=3 -> rr_op1=0x0011 one cycle later.
REQ-026 SHALL cover: rr holds ADD dst=3 with ex_result=0x00AA, MEM dst=3 result 0x00BB, WB dst=3 data 0x00CC; next instr src1=3 -> rr_op1=0x00AA; with the EX hit removed -> 0x00BB; with the MEM hit removed -> 0x00CC.
REQ-027 SHALL cover: LW dst=5 in rr, next instr src2=5 -> stall_out=1, bubble, stall_count 0->1; next cycle MEM dst=5 result 0x1234 -> rr_op2=0x1234.
REQ-028 SHALL cover: src1=0 with id_pc=0x0040 while WB writes R0=0x9999 -> rr_op1=0x0040.
REQ-029 SHALL cover: flush together with a hazard and ex_stall -> rr_valid=0, stall_out=0, stall_count unchanged; rst mid-stall -> every output cleared next edge.
REQ-030 SHALL cover: 65,536 bubbles -> stall_count stays 0xFFFF.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, register numbering and forwarding helper
package proc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  // R0 reads as the PC of the instruction being decoded.
  localparam logic [REG_AW-1:0] REG_PC = 3'd0;

  // Saturation ceiling of the load-use bubble counter.
  localparam logic [DATA_W-1:0] STALL_CNT_MAX = '1;

  // A producer forwards only when it writes a real register (never R0).
  function automatic logic fwd_hit(input logic en,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] src);
    return en && (dst != REG_PC) && (dst == src);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority operand selector: PC, EX, MEM, WB, then register file
module fwd_mux
  import proc_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_pc,
  input  logic              i_ex_en,
  input  logic [REG_AW-1:0] i_ex_dst,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_en,
  input  logic [REG_AW-1:0] i_mem_dst,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_dst,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DATA_W-1:0] i_rf_data,
  output logic [DATA_W-1:0] o_op
);

  // Youngest producer wins; R0 bypasses forwarding entirely.
  always_comb begin
    o_op = i_rf_data;
    if (i_src == REG_PC) begin
      o_op = i_pc;
    end else if (fwd_hit(i_ex_en, i_ex_dst, i_src)) begin
      o_op = i_ex_data;
    end else if (fwd_hit(i_mem_en, i_mem_dst, i_src)) begin
      o_op = i_mem_data;
    end else if (fwd_hit(i_wb_en, i_wb_dst, i_src)) begin
      o_op = i_wb_data;
    end
  end

endmodule

// File: rtl/rr_stage.sv
// rtl/rr_stage.sv - register-read stage with forwarding, load-use interlock and bubble counter
module rr_stage
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wb_en,
  input  logic              id_is_load,
  output logic [REG_AW-1:0] rf_a1,
  output logic [REG_AW-1:0] rf_a2,
  input  logic [DATA_W-1:0] rf_d1,
  input  logic [DATA_W-1:0] rf_d2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_stall,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_wb_en,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall_out,
  output logic              rr_valid,
  output logic [DATA_W-1:0] rr_pc,
  output logic [DATA_W-1:0] rr_instr,
  output logic [DATA_W-1:0] rr_op1,
  output logic [DATA_W-1:0] rr_op2,
  output logic [REG_AW-1:0] rr_dst,
  output logic              rr_wb_en,
  output logic              rr_is_load,
  output logic [DATA_W-1:0] stall_count
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [REG_AW-1:0] r_dst;
  logic              r_wb_en;
  logic              r_is_load;
  logic [DATA_W-1:0] r_stall_count;

  logic              w_ex_fwd_en;
  logic              w_mem_fwd_en;
  logic              w_hazard;
  logic              w_bubble;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;

  assign rf_a1 = id_src1;
  assign rf_a2 = id_src2;

  // A load in EX has no data yet, so it never forwards from ex_result.
  assign w_ex_fwd_en  = r_valid & r_wb_en & ~r_is_load;
  assign w_mem_fwd_en = mem_valid & mem_wb_en;

  assign w_hazard = id_valid & r_valid & r_is_load & r_wb_en & (r_dst != REG_PC) &
                    ((r_dst == id_src1) | (r_dst == id_src2));

  // A bubble is only inserted when neither flush nor an EX stall takes precedence.
  assign w_bubble  = w_hazard & ~flush & ~ex_stall;
  assign stall_out = (w_hazard | ex_stall) & ~flush & ~rst;

  fwd_mux u_fwd_op1 (
    .i_src      (id_src1),
    .i_pc       (id_pc),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_dst   (r_dst),
    .i_ex_data  (ex_result),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_dst  (mem_dst),
    .i_mem_data (mem_result),
    .i_wb_en    (wb_en),
    .i_wb_dst   (wb_dst),
    .i_wb_data  (wb_data),
    .i_rf_data  (rf_d1),
    .o_op       (w_op1)
  );

  fwd_mux u_fwd_op2 (
    .i_src      (id_src2),
    .i_pc       (id_pc),
    .i_ex_en    (w_ex_fwd_en),
    .i_ex_dst   (r_dst),
    .i_ex_data  (ex_result),
    .i_mem_en   (w_mem_fwd_en),
    .i_mem_dst  (mem_dst),
    .i_mem_data (mem_result),
    .i_wb_en    (wb_en),
    .i_wb_dst   (wb_dst),
    .i_wb_data  (wb_data),
    .i_rf_data  (rf_d2),
    .o_op       (w_op2)
  );

  // Pipeline register: reset, flush kill, EX hold, load-use bubble, or capture from ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_dst     <= '0;
      r_wb_en   <= 1'b0;
      r_is_load <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (ex_stall) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
    end else begin
      r_valid   <= id_valid;
      r_pc      <= id_pc;
      r_instr   <= id_instr;
      r_op1     <= w_op1;
      r_op2     <= w_op2;
      r_dst     <= id_dst;
      r_wb_en   <= id_wb_en;
      r_is_load <= id_is_load;
    end
  end

  // Count inserted load-use bubbles, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_bubble && (r_stall_count != STALL_CNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign rr_valid    = r_valid;
  assign rr_pc       = r_pc;
  assign rr_instr    = r_instr;
  assign rr_op1      = r_op1;
  assign rr_op2      = r_op2;
  assign rr_dst      = r_dst;
  assign rr_wb_en    = r_wb_en;
  assign rr_is_load  = r_is_load;
  assign stall_count = r_stall_count;

endmodule
